// File: rtl/run_length_tx_pkg.sv
// Shared types and constants for the run-length transmitter.
// The command layout matches the default 4-bit run-length field.
package run_length_tx_pkg;

   localparam int CMD_LEN_W = 4;

   typedef struct packed {
      logic                 level;
      logic [CMD_LEN_W-1:0] len;
   } run_cmd_t;

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } tx_state_e;

   // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
   localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/run_length_tx_cmd_fifo.sv
// Show-ahead command FIFO with wrap-bit pointers; DEPTH must be a power of two, at least 2.
module run_cmd_fifo #(
   parameter int W     = 5,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] data_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q;
   logic [AW:0]  rd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + PTR_ONE;
         if (pop_i)  rd_q <= rd_q + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
   end

   assign head_o  = mem_q[rd_q[AW-1:0]];
   assign empty_o = (wr_q == rd_q);
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/run_length_tx.sv
// Replays queued (level, len) commands on registered line `a`; RUN_LENGTH_TX_RAND_EN adds LFSR idle fill.
// States: IDLE = waiting for a command (or LFSR fill) | DRIVE = holding `a` until cnt reaches 0.
module run_length_tx
   import run_length_tx_pkg::*;
#(
   parameter int          RUN_W = 4,
   parameter int          DEPTH = 4,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_level,
   input  logic [RUN_W-1:0] cmd_len,
   input  logic             rand_mode,
   output logic             a,
   output logic             a_changed,
   output logic             busy,
   output logic             run_done,
   output logic [7:0]       runs_cnt
);

   localparam logic [RUN_W-1:0] CNT_ONE = {{(RUN_W-1){1'b0}}, 1'b1};

   tx_state_e        state_q, state_d;
   logic [RUN_W-1:0] cnt_q, cnt_d;
   logic             a_q, a_d;
   logic             a_changed_q;
   logic [7:0]       runs_q, runs_d;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [RUN_W:0]   fifo_head;
   logic             rand_active;
   logic             lfsr_bit;

   assign cmd_ready = !fifo_full && !rst;
   assign fifo_push = cmd_valid && cmd_ready;

   run_cmd_fifo #(
      .W     (RUN_W + 1),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (fifo_push),
      .data_i  ({cmd_level, cmd_len}),
      .pop_i   (fifo_pop),
      .head_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

`ifdef RUN_LENGTH_TX_RAND_EN
   logic [15:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (rst) lfsr_q <= SEED;
      else     lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
   end

   assign rand_active = rand_mode;
   assign lfsr_bit    = lfsr_q[0];
`else
   logic unused_rand;
   assign unused_rand = ^{rand_mode, SEED};
   assign rand_active = 1'b0;
   assign lfsr_bit    = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      runs_d   = runs_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (rand_active) begin
               a_d = lfsr_bit;
            end else if (!fifo_empty) begin
               fifo_pop = 1'b1;
               a_d      = fifo_head[RUN_W];
               cnt_d    = fifo_head[RUN_W-1:0];
               state_d  = DRIVE;
            end
         end
         DRIVE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_ONE;
            end else begin
               runs_d = runs_q + 8'd1;
               // Load the next run on the same edge so consecutive runs have no gap.
               if (!fifo_empty) begin
                  fifo_pop = 1'b1;
                  a_d      = fifo_head[RUN_W];
                  cnt_d    = fifo_head[RUN_W-1:0];
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         a_q         <= 1'b0;
         a_changed_q <= 1'b0;
         runs_q      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         a_changed_q <= (a_d != a_q);
         runs_q      <= runs_d;
      end
   end

   assign a         = a_q;
   assign a_changed = a_changed_q;
   assign busy      = (state_q == DRIVE);
   assign run_done  = (state_q == DRIVE) && (cnt_q == '0);
   assign runs_cnt  = runs_q;

endmodule
